// File: rtl/text_render_pkg.sv
// text_render_pkg: pipeline stage record types for the text-mode renderer.
//   stage1_t : state carried alongside the text RAM read
//   stage2_t : state carried alongside the font ROM read
//   stage3_t : resolved colour index waiting for the palette
package text_render_pkg;

    import video_pkg::*;

    localparam int PX_W   = $clog2(GLYPH_W);
    localparam int LINE_W = $clog2(GLYPH_H);

    // The cursor is an underline covering the bottom two glyph lines.
    localparam logic [LINE_W-1:0] CURSOR_FIRST_LINE = LINE_W'(GLYPH_H - 2);

    typedef struct packed {
        logic [PX_W-1:0]   px;
        logic [LINE_W-1:0] line;
        logic              de;
        logic              hs;
        logic              vs;
        logic              cur;
    } stage1_t;

    typedef struct packed {
        logic [7:0]      attr;
        logic [PX_W-1:0] px;
        logic            de;
        logic            hs;
        logic            vs;
        logic            cur;
    } stage2_t;

    typedef struct packed {
        logic [3:0] index;
        logic       de;
        logic       hs;
        logic       vs;
    } stage3_t;

    // Idle values: display disabled and syncs at their inactive (high) level,
    // so a reset never produces a spurious sync pulse downstream.
    localparam stage1_t STAGE1_IDLE = '{px: '0, line: '0, de: 1'b0, hs: 1'b1, vs: 1'b1, cur: 1'b0};
    localparam stage2_t STAGE2_IDLE = '{attr: '0, px: '0, de: 1'b0, hs: 1'b1, vs: 1'b1, cur: 1'b0};
    localparam stage3_t STAGE3_IDLE = '{index: '0, de: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/video_pkg.sv
// video_pkg: constants and the CGA colour table shared by all video modes.
//   H_VISIBLE / V_VISIBLE : visible area of the 640x480 raster
//   GLYPH_W / GLYPH_H     : character cell size in pixels
//   cga_rgb(index)        : 4-bit CGA colour index to 12-bit {r,g,b}
package video_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int GLYPH_W   = 8;
    localparam int GLYPH_H   = 16;

    // Standard 16-colour CGA palette, 4 bits per channel, packed {r,g,b}.
    // Entry 6 is the "brown" special case rather than dark yellow.
    function automatic logic [11:0] cga_rgb(input logic [3:0] index);
        logic [11:0] rgb;
        case (index)
            4'd0:    rgb = 12'h000;
            4'd1:    rgb = 12'h00A;
            4'd2:    rgb = 12'h0A0;
            4'd3:    rgb = 12'h0AA;
            4'd4:    rgb = 12'hA00;
            4'd5:    rgb = 12'hA0A;
            4'd6:    rgb = 12'hA50;
            4'd7:    rgb = 12'hAAA;
            4'd8:    rgb = 12'h555;
            4'd9:    rgb = 12'h55F;
            4'd10:   rgb = 12'h5F5;
            4'd11:   rgb = 12'h5FF;
            4'd12:   rgb = 12'hF55;
            4'd13:   rgb = 12'hF5F;
            4'd14:   rgb = 12'hFF5;
            default: rgb = 12'hFFF;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/text_render_if.sv
// text_render_if: the renderer's two memory read ports.
//   char_addr / char_data : text RAM, data {attr, char} one cycle after address
//   font_addr / font_data : font ROM, glyph row one cycle after address
//   master : renderer side (drives addresses)
//   slave  : memory side (returns data)
interface text_render_if;

    logic [11:0] char_addr;
    logic [15:0] char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;

    modport master (
        output char_addr,
        output font_addr,
        input  char_data,
        input  font_data
    );

    modport slave (
        input  char_addr,
        input  font_addr,
        output char_data,
        output font_data
    );

endinterface

// File: rtl/cga_palette.sv
// cga_palette: combinational CGA colour lookup.
//   index   in  4  colour index
//   r, g, b out 4  channel intensities
module cga_palette
    import video_pkg::*;
(
    input  logic [3:0] index,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b
);

    logic [11:0] rgb;

    assign rgb       = cga_rgb(index);
    assign {r, g, b} = rgb;

endmodule

// File: rtl/text_render.sv
// text_render: 80x30 text-mode pixel generator for 640x480@60 on the pixel clock.
//   clock, reset       : pixel clock, synchronous active-high reset
//   x, y, de           : raster position and display enable from the timing counter
//   hs_in, vs_in       : active-low syncs from the timing counter
//   cursor_en/x/y      : hardware underline cursor position
//   mem                : text RAM and font ROM read ports
//   r, g, b, hs, vs    : colour and syncs, 3 clocks behind the inputs
module text_render
    import video_pkg::*;
    import text_render_pkg::*;
#(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int BLINK_BIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [9:0]           x,
    input  logic [9:0]           y,
    input  logic                 de,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic                 cursor_en,
    input  logic [6:0]           cursor_x,
    input  logic [4:0]           cursor_y,
    text_render_if.master        mem,
    output logic [3:0]           r,
    output logic [3:0]           g,
    output logic [3:0]           b,
    output logic                 hs,
    output logic                 vs
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [11:0]      text_addr;
    logic             cursor_hit;
    logic             unused_y;

    stage1_t s1;
    stage2_t s2;
    stage3_t s3;

    logic [5:0] frame_cnt;
    logic       vs_prev;
    logic       blink;
    logic       pix_raw;
    logic       pix;
    logic [3:0] index;
    logic [3:0] pal_r;
    logic [3:0] pal_g;
    logic [3:0] pal_b;

    // Lines 512..524 alias onto rows 0..0x0C; they are always blanked by de.
    assign col       = x[PX_W +: COL_W];
    assign row       = y[LINE_W +: ROW_W];
    assign unused_y  = y[9];
    assign text_addr = 12'(int'(row) * COLS + int'(col));

    assign cursor_hit = cursor_en && (col == cursor_x) && (row == cursor_y)
                        && (y[LINE_W-1:0] >= CURSOR_FIRST_LINE);

    // Stage 0: issue the text RAM read straight from the raster position
    // (blanking included) and carry the per-pixel context alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem.char_addr <= '0;
            s1            <= STAGE1_IDLE;
        end else begin
            mem.char_addr <= text_addr;
            s1            <= '{px: x[PX_W-1:0], line: y[LINE_W-1:0], de: de,
                               hs: hs_in, vs: vs_in, cur: cursor_hit};
        end
    end

    // Stage 1: the character code selects the glyph, the line picks its row.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem.font_addr <= '0;
            s2            <= STAGE2_IDLE;
        end else begin
            mem.font_addr <= {mem.char_data[7:0], s1.line};
            s2            <= '{attr: mem.char_data[15:8], px: s1.px, de: s1.de,
                               hs: s1.hs, vs: s1.vs, cur: s1.cur};
        end
    end

    // Frame counter advances on each falling edge of vs_in; one of its bits is
    // the shared blink phase for blinking text and the cursor.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt <= '0;
            vs_prev   <= 1'b0;
        end else begin
            vs_prev <= vs_in;
            if (vs_prev && !vs_in) begin
                frame_cnt <= frame_cnt + 6'd1;
            end
        end
    end

    assign blink   = frame_cnt[BLINK_BIT];
    assign pix_raw = mem.font_data[PX_W'(GLYPH_W - 1) - s2.px];

    // Stage 2 colour choice: blinking text vanishes in the off phase, the
    // cursor lights its cell in the on phase, then fg/bg is picked from attr.
    always_comb begin
        pix = pix_raw;
        if (s2.attr[7] && !blink) begin
            pix = 1'b0;
        end
        if (s2.cur && blink) begin
            pix = 1'b1;
        end
        index = pix ? s2.attr[3:0] : {1'b0, s2.attr[6:4]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s3 <= STAGE3_IDLE;
        end else begin
            s3 <= '{index: index, de: s2.de, hs: s2.hs, vs: s2.vs};
        end
    end

    cga_palette u_palette (
        .index (s3.index),
        .r     (pal_r),
        .g     (pal_g),
        .b     (pal_b)
    );

    // Stage 3: registered outputs; blanking forces black.
    always_ff @(posedge clock) begin
        if (reset) begin
            r  <= '0;
            g  <= '0;
            b  <= '0;
            hs <= 1'b1;
            vs <= 1'b1;
        end else begin
            r  <= s3.de ? pal_r : 4'h0;
            g  <= s3.de ? pal_g : 4'h0;
            b  <= s3.de ? pal_b : 4'h0;
            hs <= s3.hs;
            vs <= s3.vs;
        end
    end

endmodule

// File: tb/tb_text_render.sv
// tb_text_render: randomized and directed bench for text_render with a
// cycle-history reference model of the text-mode rules.
module tb_text_render;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs_in;
    logic       vs_in;
    logic       cursor_en;
    logic [6:0] cursor_x;
    logic [4:0] cursor_y;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    text_render_if mem_if ();

    logic [15:0] text_ram [4096];
    logic [7:0]  font_rom [4096];

    // Memories present the word for the address registered at the previous edge.
    assign mem_if.char_data = text_ram[mem_if.char_addr];
    assign mem_if.font_data = font_rom[mem_if.font_addr];

    text_render #(.COLS(80), .ROWS(30), .BLINK_BIT(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .de        (de),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .cursor_en (cursor_en),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .mem       (mem_if),
        .r         (r),
        .g         (g),
        .b         (b),
        .hs        (hs),
        .vs        (vs)
    );

    always #20 clock = ~clock;

    logic [11:0] pal [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                              12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       rst;
        logic       cen;
        logic [6:0] cx;
        logic [4:0] cy;
    } in_t;

    in_t hist [64];
    int  cnt_hist [64];
    int  model_cnt = 0;

    // Record what every edge sampled, and the frame count after that edge.
    always @(posedge clock) begin
        int k;
        k = cyc;
        hist[k & 63] = '{x: x, y: y, de: de, hs: hs_in, vs: vs_in, rst: reset,
                         cen: cursor_en, cx: cursor_x, cy: cursor_y};
        if (reset) begin
            model_cnt = 0;
        end else if (k > 0 && !hist[(k - 1) & 63].rst && hist[(k - 1) & 63].vs && !vs_in) begin
            model_cnt = (model_cnt + 1) % 64;
        end
        cnt_hist[k & 63] = model_cnt;
        cyc = k + 1;
    end

    // Expected {rgb, hs, vs} after edge k: the pixel sampled 3 edges earlier.
    function automatic logic [13:0] model_out(input int k);
        in_t         h;
        logic [4:0]  row;
        logic [6:0]  col;
        logic [15:0] w;
        logic [7:0]  glyph;
        logic        pix;
        logic        blink;
        logic [3:0]  idx;
        for (int d = 0; d <= 3; d++) begin
            if (hist[(k - d) & 63].rst) return {12'h000, 2'b11};
        end
        h = hist[(k - 3) & 63];
        if (!h.de) return {12'h000, h.hs, h.vs};
        row   = h.y[8:4];
        col   = h.x[9:3];
        w     = text_ram[int'(row) * 80 + int'(col)];
        glyph = font_rom[{w[7:0], h.y[3:0]}];
        pix   = glyph[7 - int'(h.x[2:0])];
        blink = cnt_hist[(k - 2) & 63][4];
        if (w[15] && !blink) pix = 1'b0;
        if (h.cen && col == h.cx && row == h.cy && h.y[3:0] >= 4'd14 && blink) pix = 1'b1;
        idx = pix ? w[11:8] : {1'b0, w[14:12]};
        return {pal[idx], h.hs, h.vs};
    endfunction

    function automatic logic [11:0] model_addr(input int k);
        in_t h;
        h = hist[k & 63];
        if (h.rst) return 12'd0;
        return 12'(int'(h.y[8:4]) * 80 + int'(h.x[9:3]));
    endfunction

    // Continuous comparison against the model on every falling edge.
    always @(negedge clock) begin
        logic [13:0] want;
        logic [11:0] want_addr;
        if (cyc >= 4) begin
            want      = model_out(cyc - 1);
            want_addr = model_addr(cyc - 1);
            checks++;
            if ({r, g, b, hs, vs} !== want) begin
                errors++;
                $display("[TB] FAIL pixel edge=%0d got=%h/%b%b want=%h/%b%b",
                         cyc - 1, {r, g, b}, hs, vs, want[13:2], want[1], want[0]);
            end
            checks++;
            if (mem_if.char_addr !== want_addr) begin
                errors++;
                $display("[TB] FAIL char_addr edge=%0d got=%0d want=%0d",
                         cyc - 1, mem_if.char_addr, want_addr);
            end
        end
    end

    task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic apply_stimulus(input int nx, input int ny, input logic nde,
                                  input logic nhs, input logic nvs);
        @(negedge clock);
        x     = 10'(nx);
        y     = 10'(ny);
        de    = nde;
        hs_in = nhs;
        vs_in = nvs;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic vs_falls(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            vs_in = 1'b1;
            @(negedge clock);
            vs_in = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        x = '0; y = '0; de = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        cursor_en = 1'b0; cursor_x = '0; cursor_y = '0;
        for (int i = 0; i < 4096; i++) begin
            text_ram[i] = 16'($urandom);
            font_rom[i] = 8'($urandom);
        end
        text_ram[162] = 16'h0741;
        text_ram[0]   = 16'h1E41;
        text_ram[1]   = 16'h8F42;
        text_ram[245] = 16'h0720;
        font_rom[12'h413] = 8'h80;
        for (int l = 0; l < 16; l++) begin
            font_rom[{8'h42, 4'(l)}] = 8'hFF;
            font_rom[{8'h20, 4'(l)}] = 8'h00;
        end

        wait_edges(3);
        check_output("reset_rgb", {4'h0, r, g, b}, 16'h0000);
        check_output("reset_sync", {14'h0, hs, vs}, 16'h0003);
        check_output("reset_char_addr", {4'h0, mem_if.char_addr}, 16'h0000);
        check_output("reset_font_addr", {4'h0, mem_if.font_addr}, 16'h0000);

        @(negedge clock);
        reset = 1'b0; x = 10'd17; y = 10'd35; de = 1'b1;
        wait_edges(1);
        check_output("char_addr_17_35", {4'h0, mem_if.char_addr}, 16'd162);
        wait_edges(1);
        check_output("font_addr_0741", {4'h0, mem_if.font_addr}, 16'h0413);

        apply_stimulus(0, 3, 1'b1, 1'b1, 1'b1);
        wait_edges(4);
        check_output("pixel_x0", {4'h0, r, g, b}, 16'h0FF5);
        apply_stimulus(1, 3, 1'b1, 1'b1, 1'b1);
        wait_edges(3);
        check_output("latency_hold", {4'h0, r, g, b}, 16'h0FF5);
        wait_edges(1);
        check_output("pixel_x1", {4'h0, r, g, b}, 16'h000A);

        apply_stimulus(0, 3, 1'b0, 1'b0, 1'b1);
        wait_edges(3);
        check_output("hs_before", {15'h0, hs}, 16'h0001);
        wait_edges(1);
        check_output("blank_rgb", {4'h0, r, g, b}, 16'h0000);
        check_output("hs_delay3", {15'h0, hs}, 16'h0000);
        apply_stimulus(0, 3, 1'b0, 1'b1, 1'b0);
        wait_edges(3);
        check_output("vs_before", {15'h0, vs}, 16'h0001);
        wait_edges(1);
        check_output("vs_delay3", {15'h0, vs}, 16'h0000);

        pulse_reset();
        apply_stimulus(8, 0, 1'b1, 1'b1, 1'b1);
        wait_edges(5);
        check_output("blink_cnt0", {4'h0, r, g, b}, 16'h0000);
        vs_falls(15);
        wait_edges(5);
        check_output("blink_cnt15", {4'h0, r, g, b}, 16'h0000);
        vs_falls(1);
        wait_edges(5);
        check_output("blink_cnt16", {4'h0, r, g, b}, 16'h0FFF);
        vs_falls(48);
        wait_edges(5);
        check_output("blink_wrap64", {4'h0, r, g, b}, 16'h0000);

        pulse_reset();
        cursor_en = 1'b1; cursor_x = 7'd5; cursor_y = 5'd3;
        apply_stimulus(40, 62, 1'b1, 1'b1, 1'b1);
        vs_falls(16);
        wait_edges(5);
        check_output("cursor_y62", {4'h0, r, g, b}, 16'h0AAA);
        apply_stimulus(40, 63, 1'b1, 1'b1, 1'b0);
        wait_edges(5);
        check_output("cursor_y63", {4'h0, r, g, b}, 16'h0AAA);
        apply_stimulus(40, 61, 1'b1, 1'b1, 1'b0);
        wait_edges(5);
        check_output("cursor_y61", {4'h0, r, g, b}, 16'h0000);
        cursor_en = 1'b0;
        apply_stimulus(40, 62, 1'b1, 1'b1, 1'b0);
        wait_edges(5);
        check_output("cursor_off", {4'h0, r, g, b}, 16'h0000);

        apply_stimulus(0, 3, 1'b1, 1'b0, 1'b0);
        wait_edges(4);
        check_output("pre_reset", {4'h0, r, g, b}, 16'h0FF5);
        @(negedge clock);
        reset = 1'b1;
        wait_edges(1);
        check_output("reset_mid_rgb", {4'h0, r, g, b}, 16'h0000);
        check_output("reset_mid_sync", {14'h0, hs, vs}, 16'h0003);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        wait_edges(3);
        check_output("reset_hold", {4'h0, r, g, b}, 16'h0000);
        wait_edges(1);
        check_output("reset_resume", {4'h0, r, g, b}, 16'h0FF5);
        check_output("reset_resume_sync", {14'h0, hs, vs}, 16'h0000);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 99) == 0);
            if (i % 40 == 0) begin
                cursor_en = ($urandom_range(0, 3) != 0);
                cursor_x  = 7'($urandom_range(0, 79));
                cursor_y  = 5'($urandom_range(0, 29));
            end
            if ($urandom_range(0, 1) == 1) begin
                x = 10'(int'(cursor_x) * 8 + int'($urandom_range(0, 7)));
                y = 10'(int'(cursor_y) * 16 + int'($urandom_range(12, 15)));
            end else begin
                x = 10'($urandom_range(0, 799));
                y = 10'($urandom_range(0, 524));
            end
            de    = (x < 10'd640) && (y < 10'd480);
            hs_in = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) vs_in = ~vs_in;
        end
        reset = 1'b0;
        wait_edges(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_render.md
Name: text_render

Overview:
- 80x30 text-mode pixel generator for the 640x480@60 VGA path, clocked on the 25 MHz pixel clock.
- Upstream of the `video` output stage.
- Consumes pixel coordinates and syncs from the timing counter.
- Fetches character/attribute words from text RAM and glyph rows from font ROM, then emits 4-bit-per-channel colour with syncs delayed to match.
- Adds a hardware cursor and attribute blink driven by a frame counter.

Parameters:
- COLS, 80, text columns per row.
- ROWS, 30, text rows (16-pixel glyph height).
- BLINK_BIT, 4, frame-counter bit used as blink phase (32-frame period).

Ports:
- clock  in  1  pixel clock, 25 MHz.
- reset  in  1  synchronous, active-high.
- x  in  10  current pixel column, 0..799.
- y  in  10  current pixel line, 0..524.
- de  in  1  display enable (x<640 && y<480).
- hs_in  in  1  horizontal sync, active-low.
- vs_in  in  1  vertical sync, active-low.
- char_addr  out  12  text RAM address, row*COLS+col.
- char_data  in  16  {attr[7:0], char[7:0]}; valid 1 cycle after char_addr.
- font_addr  out  12  {char[7:0], glyph_line[3:0]}.
- font_data  in  8  glyph row, bit7 = leftmost pixel; valid 1 cycle after font_addr.
- cursor_en  in  1  cursor enable.
- cursor_x  in  7  cursor column.
- cursor_y  in  5  cursor row.
- r  out  4  red.
- g  out  4  green.
- b  out  4  blue.
- hs  out  1  delayed hs_in.
- vs  out  1  delayed vs_in.

Behaviour:
- Reset values:
  - r, g, b = 0.
  - hs = 1, vs = 1.
  - char_addr = 0, font_addr = 0.
  - All pipeline registers cleared; de pipe = 0.
  - Frame counter = 0.
- Pipeline, fixed latency of 3 clocks from x/y/de/hs_in/vs_in to r/g/b/hs/vs:
  - S0 (registered on clock edge N): char_addr = (y[8:4]<<6)+(y[8:4]<<4)+x[9:3]. Latch x[2:0], y[3:0], de, syncs, cursor hit into the stage-1 regs.
  - S1 (edge N+1): char_data valid. font_addr = {char_data[7:0], y1[3:0]}. Latch attr, x[2:0], de, syncs, cursor hit into the stage-2 regs.
  - S2 (edge N+2): font_data valid. pix = font_data[7 - x2[2:0]]. Compute colour index.
  - S3 (edge N+3): r/g/b/hs/vs registered outputs.
- Address range: char_addr is computed from x/y every cycle, including blanking. Out-of-range addresses (>=2400) are tolerated because de masks the colour.
- Colour selection:
  - fg = attr[3:0], bg = attr[6:4] (zero-extended to 4 bits), blink = frame_cnt[BLINK_BIT].
  - If attr[7]=1 and blink=0, pix is forced to 0 (blinking text hidden).
  - Cursor hit requires all of: cursor_en, col==cursor_x, row==cursor_y, y[3:0]>=14. On a hit with blink=1, pix is forced to 1.
  - index = pix ? fg : bg.
  - de=0 at S3 gives r=g=b=0 regardless of index.
- Palette: 16-entry CGA palette to 12-bit RGB (4 bits per channel).
  - 0 000
  - 1 00A
  - 2 0A0
  - 3 0AA
  - 4 A00
  - 5 A0A
  - 6 A50
  - 7 AAA
  - 8 555
  - 9 55F
  - 10 5F5
  - 11 5FF
  - 12 F55
  - 13 F5F
  - 14 FF5
  - 15 FFF
- Frame counter: 6-bit. Increments once per falling edge of vs_in (edge detect on a registered copy). Wraps 63->0.
- Simultaneous events: reset wins over all pipeline updates. Cursor and attribute blink share one phase bit.
- Reset mid-frame: outputs return to reset values on the next edge. Normal output resumes 3 clocks after reset deasserts, with no resync needed because addresses derive combinationally from x/y.

Decomposition:
- Shared package `video_pkg`:
  - Constants H_VISIBLE=640, V_VISIBLE=480, GLYPH_W=8, GLYPH_H=16.
  - The 16-entry CGA palette as a constant function `cga_rgb(index) -> 12 bits`.
- One sub-module: `cga_palette` (combinational index to {r,g,b}), reused by future graphics modes.
- Text RAM and font ROM stay outside the block as synchronous 1-cycle-latency memories.

Test Plan:
- Address mapping: x=17, y=35, de=1 -> char_addr=162 (row 2, col 2) one clock later. Given char_data=0x0741, font_addr=0x413 one clock after that.
- Pixel and latency: char 0x41, attr 0x1E, font_data=0x80, x[2:0]=0 -> r,g,b = F,F,5 exactly 3 clocks after x/y applied. With x[2:0]=1 -> 0,0,A.
- Blanking: de=0 with a lit glyph -> r=g=b=0. hs/vs follow hs_in/vs_in delayed by exactly 3 clocks.
- Blink: attr 0x8F, glyph 0xFF.
  - After 16 vs_in falling edges (blink=1), output = FFF.
  - At frame counter 0..15, output = 000.
  - Counter value 64 wraps to 0.
- Cursor: cursor_en=1, cursor_x=5, cursor_y=3, space glyph (0x00), attr 0x07, blink=1:
  - y=62/63 -> AAA.
  - y=61 -> 000.
  - cursor_en=0 -> 000.
- Reset: assert reset mid-line for 2 cycles -> r/g/b=0, hs=vs=1 on the next edge. Valid pixels resume on the 3rd edge after deassertion.
